// File: rtl/mmu_wb_cache_if.sv
// mmu_wb_cache_if: CPU strb/mfc request side plus memory bus side; slave = the MMU, master = CPU and memory
interface mmu_wb_cache_if #(parameter int ADDR_SIZE = 32);
  logic strb, rw, mfc, err, flush, busy;
  logic [1:0] size;
  logic [ADDR_SIZE-1:0] mar, bus_addr;
  logic [31:0] wdata, rdata, bus_wdata, bus_rdata;
  logic bus_strb, bus_rw, bus_mfc;
  modport slave(
    input strb, rw, size, mar, wdata, flush, bus_rdata, bus_mfc,
    output rdata, mfc, err, busy, bus_strb, bus_rw, bus_addr, bus_wdata
  );
  modport master(
    output strb, rw, size, mar, wdata, flush, bus_rdata, bus_mfc,
    input rdata, mfc, err, busy, bus_strb, bus_rw, bus_addr, bus_wdata
  );
endinterface

// File: rtl/mmu_wb_cache.sv
// mmu_wb_cache: CPU byte/half/word accesses over a direct-mapped write-back word cache; ports clk, rst, m (slave: strb/rw/size/mar/wdata/flush in, rdata/mfc/err/busy out, bus_* memory side)
module mmu_wb_cache #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int LINES = 4
) (
  input logic clk,
  input logic rst,
  mmu_wb_cache_if.slave m
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TW = ADDR_SIZE - IDX_W - 2;
  typedef enum logic [3:0] {IDLE, WB, WB_REL, FILL, FILL_REL, DONE, FL_SCAN, FL_WB, FL_REL} state_t;
  state_t r_state, w_next;
  logic [LINES-1:0] r_valid, r_dirty;
  logic [TW-1:0] r_tag [LINES];
  logic [WORD_SIZE-1:0] r_data [LINES];
  logic [IDX_W-1:0] r_fidx;
  logic r_mfc, r_err, r_bus_strb, r_bus_rw;
  logic [ADDR_SIZE-1:0] r_bus_addr;
  logic [WORD_SIZE-1:0] r_bus_wdata, r_rdata;
  logic [IDX_W-1:0] w_idx;
  logic [TW-1:0] w_tag;
  logic [1:0] w_lane;
  logic [4:0] w_sh;
  logic w_mis, w_hit, w_vdirty, w_wfull, w_busy;
  logic [WORD_SIZE-1:0] w_line, w_mask, w_load, w_merged;
  assign w_lane = m.mar[1:0];
  assign w_sh = {w_lane, 3'b000};
  assign w_idx = m.mar[IDX_W+1:2];
  assign w_tag = m.mar[ADDR_SIZE-1:IDX_W+2];
  assign w_mis = (m.size == 2'b01 & m.mar[0]) | (m.size[1] & |w_lane);
  assign w_line = r_data[w_idx];
  assign w_hit = r_valid[w_idx] & (r_tag[w_idx] == w_tag);
  assign w_vdirty = r_valid[w_idx] & r_dirty[w_idx];
  assign w_wfull = !m.rw & m.size[1];
  assign w_mask = m.size == 2'b00 ? WORD_SIZE'(8'hFF) : m.size == 2'b01 ? WORD_SIZE'(16'hFFFF) : '1;
  assign w_load = (w_line >> w_sh) & w_mask;
  assign w_merged = (w_line & ~(w_mask << w_sh)) | ((m.wdata & w_mask) << w_sh);
  assign w_busy = r_state inside {FL_SCAN, FL_WB, FL_REL};
  assign m.rdata = r_rdata;
  assign m.mfc = r_mfc;
  assign m.err = r_err;
  assign m.busy = w_busy;
  assign m.bus_strb = r_bus_strb;
  assign m.bus_rw = r_bus_rw;
  assign m.bus_addr = r_bus_addr;
  assign m.bus_wdata = r_bus_wdata;
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     w_next = m.strb ? ((w_mis | w_hit | (!w_vdirty & w_wfull)) ? DONE : w_vdirty ? WB : FILL)
                                : m.flush ? FL_SCAN : IDLE;
      WB:       w_next = m.bus_mfc ? WB_REL : WB;
      WB_REL:   w_next = m.bus_mfc ? WB_REL : w_wfull ? DONE : FILL;
      FILL:     w_next = m.bus_mfc ? FILL_REL : FILL;
      FILL_REL: w_next = m.bus_mfc ? FILL_REL : DONE;
      DONE:     w_next = (r_mfc & !m.strb) ? IDLE : DONE;
      FL_SCAN:  w_next = (r_valid[r_fidx] & r_dirty[r_fidx]) ? FL_WB : &r_fidx ? IDLE : FL_SCAN;
      FL_WB:    w_next = m.bus_mfc ? FL_REL : FL_WB;
      FL_REL:   w_next = m.bus_mfc ? FL_REL : FL_SCAN;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int i = 0; i < LINES; i++) begin
        r_tag[i] <= '0;
        r_data[i] <= '0;
      end
      r_fidx <= '0;
      r_mfc <= 1'b0;
      r_err <= 1'b0;
      r_rdata <= '0;
      r_bus_strb <= 1'b0;
      r_bus_rw <= 1'b1;
      r_bus_addr <= '0;
      r_bus_wdata <= '0;
    end else begin
      if (r_state == IDLE && w_next == WB) begin
        r_bus_strb <= 1'b1;
        r_bus_rw <= 1'b0;
        r_bus_addr <= {r_tag[w_idx], w_idx, 2'b00};
        r_bus_wdata <= w_line;
      end
      if ((r_state == IDLE || r_state == WB_REL) && w_next == FILL) begin
        r_bus_strb <= 1'b1;
        r_bus_rw <= 1'b1;
        r_bus_addr <= {w_tag, w_idx, 2'b00};
      end
      if (r_state == FL_SCAN && w_next == FL_WB) begin
        r_bus_strb <= 1'b1;
        r_bus_rw <= 1'b0;
        r_bus_addr <= {r_tag[r_fidx], r_fidx, 2'b00};
        r_bus_wdata <= r_data[r_fidx];
      end
      if ((r_state == WB || r_state == FILL || r_state == FL_WB) && m.bus_mfc) r_bus_strb <= 1'b0;
      if (r_state == FILL && m.bus_mfc) begin
        r_data[w_idx] <= m.bus_rdata;
        r_tag[w_idx] <= w_tag;
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      // whole-word store on a clean miss claims the entry without a fill
      if ((r_state == IDLE || r_state == WB_REL) && w_next == DONE && !w_hit && !w_mis) begin
        r_tag[w_idx] <= w_tag;
        r_valid[w_idx] <= 1'b1;
        r_dirty[w_idx] <= 1'b0;
      end
      // every access is performed here against an entry that now hits
      if (r_state == DONE && !r_mfc) begin
        r_mfc <= 1'b1;
        r_err <= w_mis;
        if (!w_mis && m.rw) r_rdata <= w_load;
        if (!w_mis && !m.rw) begin
          r_data[w_idx] <= w_merged;
          r_dirty[w_idx] <= 1'b1;
        end
      end
      if (r_state == DONE && r_mfc && !m.strb) begin
        r_mfc <= 1'b0;
        r_err <= 1'b0;
      end
      if (r_state == IDLE && w_next == FL_SCAN) r_fidx <= '0;
      if (r_state == FL_SCAN && w_next == FL_SCAN) r_fidx <= r_fidx + IDX_W'(1);
      if (r_state == FL_SCAN && w_next == IDLE) begin
        r_valid <= '0;
        r_dirty <= '0;
      end
      if (r_state == FL_REL && !m.bus_mfc) r_dirty[r_fidx] <= 1'b0;
    end
  end
endmodule
